// File: rtl/calc_req_driver.sv
// ---------------------------------------------------------------------------
// calc_req_driver
//
// Drives one calc1 request port. It accepts one request at a time from a
// sequencer and sends the two-cycle command/operand sequence to the DUT. It
// then waits a bounded number of cycles for the DUT response. Finally it
// publishes a checker bundle with the observed response and the expected one,
// which is computed from the latched operands.
//
// Timeline:
//   start sampled -> SEND1 -> SEND2 -> WAIT (1..TIMEOUT+1 cycles) -> DONE -> IDLE
//   Start-to-done latency is 3 + response delay, where a response in the first
//   WAIT cycle has a delay of 1.
//
// Ports
//   c_clk          sole clock, rising edge
//   reset          synchronous, active-high
//   start          one-cycle request strobe, honoured only in IDLE
//   cmd/op1/op2    calc1 command and operands, latched at start
//   test_num       test identifier, latched at start
//   req_cmd_out    command presented to the DUT port
//   req_data_out   operand data presented to the DUT port
//   dut_resp       DUT response code (0 none, 1 success, 2 error)
//   dut_data       DUT response data
//   busy           high whenever the driver is not idle
//   done           one-cycle pulse; the checker bundle is valid
//   resp_port, got_resp, got_data, exp_resp, exp_data, done_test_num
//                  checker bundle, held from done until the next completion
//   timeout        set with done when no response arrived in time
//   spurious       one-cycle pulse for a response seen outside WAIT
// ---------------------------------------------------------------------------
module calc_req_driver #(
    parameter int PORT_ID = 1,
    parameter int TIMEOUT = 64
) (
    input  logic        c_clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  cmd,
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    input  logic [31:0] test_num,
    output logic [3:0]  req_cmd_out,
    output logic [31:0] req_data_out,
    input  logic [1:0]  dut_resp,
    input  logic [31:0] dut_data,
    output logic        busy,
    output logic        done,
    output logic [2:0]  resp_port,
    output logic [1:0]  got_resp,
    output logic [31:0] got_data,
    output logic [1:0]  exp_resp,
    output logic [31:0] exp_data,
    output logic [31:0] done_test_num,
    output logic        timeout,
    output logic        spurious
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND1,
        S_SEND2,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic [3:0] CMD_ADD = 4'd1;
    localparam logic [3:0] CMD_SUB = 4'd2;
    localparam logic [3:0] CMD_SHL = 4'd5;
    localparam logic [3:0] CMD_SHR = 4'd6;

    localparam logic [1:0] RESP_OK  = 2'd1;
    localparam logic [1:0] RESP_ERR = 2'd2;

    // The counter must be able to hold TIMEOUT itself.
    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    state_t         state, state_d;
    logic [CW-1:0]  cnt, cnt_d;

    logic [3:0]     cmd_q;
    logic [31:0]    op1_q, op2_q, tn_q;
    logic           latch;

    logic [3:0]     req_cmd_d;
    logic [31:0]    req_data_d;
    logic           finish;
    logic [1:0]     fin_resp;
    logic [31:0]    fin_data;
    logic           fin_timeout;

    logic [1:0]     model_resp;
    logic [31:0]    model_data;
    logic [32:0]    sum33;

    // -----------------------------------------------------------------------
    // Expected-result model computed from the latched request.
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every always_comb output gets a default first so that no path
        // leaves it unassigned, which would infer a latch.
        model_resp = RESP_ERR;
        model_data = '0;
        sum33      = {1'b0, op1_q} + {1'b0, op2_q};
        unique case (cmd_q)
            CMD_ADD: begin
                // A carry out of bit 31 is an overflow, never a wrapped success.
                if (!sum33[32]) begin
                    model_resp = RESP_OK;
                    model_data = sum33[31:0];
                end
            end
            CMD_SUB: begin
                if (op2_q <= op1_q) begin
                    model_resp = RESP_OK;
                    model_data = op1_q - op2_q;
                end
            end
            // Shift amount is the low five bits only; upper bits are ignored.
            CMD_SHL: begin
                model_resp = RESP_OK;
                model_data = op1_q << op2_q[4:0];
            end
            CMD_SHR: begin
                model_resp = RESP_OK;
                model_data = op1_q >> op2_q[4:0];
            end
            default: ;
        endcase
    end

    // -----------------------------------------------------------------------
    // Next-state and next-output logic. The outputs are registered together
    // with the state, so each output value is visible in the state it belongs to.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        req_cmd_d   = '0;
        req_data_d  = '0;
        latch       = 1'b0;
        finish      = 1'b0;
        fin_resp    = '0;
        fin_data    = '0;
        fin_timeout = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_SEND1;
                    latch      = 1'b1;
                    req_cmd_d  = cmd;
                    req_data_d = op1;
                end
            end
            S_SEND1: begin
                state_d    = S_SEND2;
                req_data_d = op2_q;
            end
            S_SEND2: begin
                state_d = S_WAIT;
                cnt_d   = '0;
            end
            S_WAIT: begin
                // A response in the final counted cycle still wins over timeout.
                if (dut_resp != 2'd0) begin
                    state_d  = S_DONE;
                    finish   = 1'b1;
                    fin_resp = dut_resp;
                    fin_data = dut_data;
                end else if (cnt == CW'(TIMEOUT)) begin
                    state_d     = S_DONE;
                    finish      = 1'b1;
                    fin_timeout = 1'b1;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // State and output registers.
    // -----------------------------------------------------------------------
    always_ff @(posedge c_clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples pre-edge values regardless of statement order.
        if (reset) begin
            state         <= S_IDLE;
            cnt           <= '0;
            req_cmd_out   <= '0;
            req_data_out  <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            spurious      <= 1'b0;
            timeout       <= 1'b0;
            resp_port     <= '0;
            got_resp      <= '0;
            got_data      <= '0;
            exp_resp      <= '0;
            exp_data      <= '0;
            done_test_num <= '0;
        end else begin
            state        <= state_d;
            cnt          <= cnt_d;
            req_cmd_out  <= req_cmd_d;
            req_data_out <= req_data_d;
            busy         <= (state_d != S_IDLE);
            done         <= finish;
            // Responses outside WAIT are flagged and dropped.
            spurious     <= (dut_resp != 2'd0) && (state != S_WAIT);
            if (finish) begin
                timeout       <= fin_timeout;
                resp_port     <= 3'(PORT_ID);
                got_resp      <= fin_resp;
                got_data      <= fin_data;
                exp_resp      <= model_resp;
                exp_data      <= model_data;
                done_test_num <= tn_q;
            end
        end
    end

    // NOTE: the request latch is plain datapath storage without reset; it is
    // only read after a start has loaded it.
    always_ff @(posedge c_clk) begin
        if (latch && !reset) begin
            cmd_q <= cmd;
            op1_q <= op1;
            op2_q <= op2;
            tn_q  <= test_num;
        end
    end

endmodule

// File: tb/tb_calc_req_driver.sv
// ---------------------------------------------------------------------------
// tb_calc_req_driver
//
// Directed bench for calc_req_driver with PORT_ID=3 and TIMEOUT=8. It acts as
// both the sequencer and the DUT port, and checks request sequencing, latency,
// the expected-result model, timeout handling, reset abort and spurious
// responses against hand-computed values.
// ---------------------------------------------------------------------------
module tb_calc_req_driver;

    localparam int PORT = 3;
    localparam int TO   = 8;

    logic        c_clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  cmd;
    logic [31:0] op1, op2, test_num;
    logic [3:0]  req_cmd_out;
    logic [31:0] req_data_out;
    logic [1:0]  dut_resp;
    logic [31:0] dut_data;
    logic        busy, done;
    logic [2:0]  resp_port;
    logic [1:0]  got_resp, exp_resp;
    logic [31:0] got_data, exp_data, done_test_num;
    logic        timeout, spurious;

    int n_tests = 0;
    int n_fail  = 0;

    calc_req_driver #(.PORT_ID(PORT), .TIMEOUT(TO)) dut (
        .c_clk         (c_clk),
        .reset         (reset),
        .start         (start),
        .cmd           (cmd),
        .op1           (op1),
        .op2           (op2),
        .test_num      (test_num),
        .req_cmd_out   (req_cmd_out),
        .req_data_out  (req_data_out),
        .dut_resp      (dut_resp),
        .dut_data      (dut_data),
        .busy          (busy),
        .done          (done),
        .resp_port     (resp_port),
        .got_resp      (got_resp),
        .got_data      (got_data),
        .exp_resp      (exp_resp),
        .exp_data      (exp_data),
        .done_test_num (done_test_num),
        .timeout       (timeout),
        .spurious      (spurious)
    );

    always #5 c_clk = ~c_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge c_clk);
        #1;
    endtask

    // One complete transaction. delay is the 1-based WAIT cycle in which the
    // response is driven; 0 keeps the DUT silent. busy_start re-strobes start
    // with junk during SEND1/SEND2.
    task automatic run_txn(input string name, input logic [3:0] c, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] tn, input int delay,
                           input logic [1:0] r, input logic [31:0] d,
                           input logic [1:0] er, input logic [31:0] ed, input bit busy_start);
        int lat;
        int exp_lat;
        lat      = 0;
        cmd      = c;
        op1      = a;
        op2      = b;
        test_num = tn;
        start    = 1'b1;
        step();                                   // SEND1
        if (busy_start) begin
            cmd = 4'd2; op1 = 32'd999; op2 = 32'd1; test_num = 32'hdead;
        end else begin
            start = 1'b0;
        end
        check({name, " send1_cmd"}, 32'(req_cmd_out), 32'(c));
        check({name, " send1_data"}, req_data_out, a);
        check({name, " busy"}, 32'(busy), 32'd1);
        step();                                   // SEND2
        check({name, " send2_cmd"}, 32'(req_cmd_out), 32'd0);
        check({name, " send2_data"}, req_data_out, b);
        step();                                   // first WAIT cycle
        start = 1'b0;
        check({name, " wait_data"}, req_data_out, 32'd0);
        for (int cy = 3; cy < 60; cy++) begin
            dut_resp = 2'd0;
            dut_data = 32'd0;
            if (done) begin
                lat = cy;
                break;
            end
            if (delay != 0 && cy - 2 == delay) begin
                dut_resp = r;
                dut_data = d;
            end
            step();
        end
        exp_lat = (delay == 0) ? TO + 4 : delay + 3;
        check({name, " latency"}, 32'(lat), 32'(exp_lat));
        if (lat != 0) begin
            check({name, " got_resp"}, 32'(got_resp), (delay == 0) ? 32'd0 : 32'(r));
            check({name, " got_data"}, got_data, (delay == 0) ? 32'd0 : d);
            check({name, " exp_resp"}, 32'(exp_resp), 32'(er));
            check({name, " exp_data"}, exp_data, ed);
            check({name, " timeout"}, 32'(timeout), (delay == 0) ? 32'd1 : 32'd0);
            check({name, " resp_port"}, 32'(resp_port), 32'(PORT));
            check({name, " test_num"}, done_test_num, tn);
        end
        step();
        check({name, " done_pulse"}, 32'(done), 32'd0);
        check({name, " idle"}, 32'(busy), 32'd0);
        check({name, " hold"}, exp_data, ed);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b1; cmd = 4'd1; op1 = 32'd1; op2 = 32'd1;
        test_num = 32'd0; dut_resp = 2'd0; dut_data = 32'd0;
        step();
        step();
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst req_cmd", 32'(req_cmd_out), 32'd0);
        check("rst req_data", req_data_out, 32'd0);
        check("rst spurious", 32'(spurious), 32'd0);
        check("rst timeout", 32'(timeout), 32'd0);
        check("rst resp_port", 32'(resp_port), 32'd0);
        check("rst exp_resp", 32'(exp_resp), 32'd0);
        reset = 1'b0; start = 1'b0;
        step();
        check("rst start_ignored", 32'(busy), 32'd0);

        run_txn("add",      4'd1, 32'd5, 32'd7, 32'd11, 4, 2'd1, 32'd12, 2'd1, 32'd12, 1'b0);
        run_txn("add_ovf",  4'd1, 32'hFFFFFFFF, 32'd1, 32'd12, 1, 2'd2, 32'd0, 2'd2, 32'd0, 1'b0);
        run_txn("add_max",  4'd1, 32'hFFFFFFFE, 32'd1, 32'd13, 2, 2'd1, 32'hFFFFFFFF, 2'd1, 32'hFFFFFFFF, 1'b0);
        run_txn("shl",      4'd5, 32'd1, 32'hFFFFFFE4, 32'd14, 1, 2'd1, 32'h10, 2'd1, 32'h10, 1'b0);
        run_txn("shr",      4'd6, 32'h80000000, 32'd31, 32'd15, 3, 2'd1, 32'd1, 2'd1, 32'd1, 1'b0);
        run_txn("invalid",  4'd9, 32'd3, 32'd4, 32'd16, 1, 2'd2, 32'd0, 2'd2, 32'd0, 1'b0);
        run_txn("sub",      4'd2, 32'd10, 32'd3, 32'd17, 1, 2'd1, 32'd7, 2'd1, 32'd7, 1'b0);
        run_txn("sub_unf",  4'd2, 32'd3, 32'd5, 32'd18, 1, 2'd2, 32'd0, 2'd2, 32'd0, 1'b0);
        run_txn("timeout",  4'd1, 32'd1, 32'd2, 32'd19, 0, 2'd0, 32'd0, 2'd1, 32'd3, 1'b0);
        run_txn("last_cyc", 4'd1, 32'd2, 32'd2, 32'd20, TO + 1, 2'd1, 32'd4, 2'd1, 32'd4, 1'b0);
        run_txn("busy_st",  4'd1, 32'd8, 32'd9, 32'd100, 1, 2'd1, 32'd17, 2'd1, 32'd17, 1'b1);
        run_txn("b2b",      4'd2, 32'd9, 32'd8, 32'd200, 1, 2'd1, 32'd1, 2'd1, 32'd1, 1'b0);

        // Reset while waiting, then a late DUT response in IDLE.
        cmd = 4'd1; op1 = 32'd1; op2 = 32'd1; test_num = 32'd300; start = 1'b1;
        step();                                   // SEND1
        start = 1'b0;
        step();                                   // SEND2
        step();                                   // WAIT
        step();                                   // WAIT
        reset = 1'b1;
        step();
        reset    = 1'b0;
        dut_resp = 2'd1;
        dut_data = 32'd2;
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        check("abort req_cmd", 32'(req_cmd_out), 32'd0);
        check("abort got_resp", 32'(got_resp), 32'd0);
        check("abort test_num", done_test_num, 32'd0);
        step();
        dut_resp = 2'd0;
        dut_data = 32'd0;
        check("spurious set", 32'(spurious), 32'd1);
        check("spurious no_done", 32'(done), 32'd0);
        check("spurious busy", 32'(busy), 32'd0);
        step();
        check("spurious pulse", 32'(spurious), 32'd0);
        check("spurious no_done2", 32'(done), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
